// File: rtl/apb_cmd_master_if.sv
// Command/response stream plus APB3 bus bundled for apb_cmd_master.
interface apb_cmd_master_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-command APB3 master: one SETUP/ACCESS transfer per command, with a
// held response carrying read data, slave error and an optional timeout.
module apb_cmd_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  apb_cmd_master_if.master bus
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = (TIMEOUT == 0) ? {CW{1'b1}} : CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           wcnt_q, wcnt_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic                    timed_out;

  // Fires only at the end of the TIMEOUT-th ACCESS cycle; pready has priority.
  assign timed_out = (TIMEOUT != 0) && !bus.pready && (wcnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wcnt_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid)            state_d = SETUP;
      SETUP:                                 state_d = ACCESS;
      ACCESS:  if (bus.pready || timed_out)  state_d = RESP;
      RESP:    if (bus.rsp_ready)            state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up
  // with the state register on every edge.
  always_comb begin
    wcnt_d        = wcnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    psel_d        = (state_d == SETUP) || (state_d == ACCESS);
    penable_d     = (state_d == ACCESS);
    rsp_valid_d   = (state_d == RESP);
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          wcnt_d   = '0;
        end
      end
      ACCESS: begin
        if (bus.pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
        end else if (timed_out) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (wcnt_q != CNT_MAX) begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: behavioural APB register slave, table of
// commands checked through a response scoreboard, plus latency/backpressure/reset sequences.
module tb_apb_cmd_master;

  logic clk;
  logic rst_n;

  apb_cmd_master_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) ifc ();

  apb_cmd_master #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       write;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         waits;      // 255 = slave never raises pready
    logic       err;
    logic [7:0] exp_rdata;
    logic       exp_err;
    logic       exp_to;
    int         exp_acc;
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       to;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] mem [16];
  int         cur_waits = 0;
  logic       cur_err = 1'b0;
  int         acc_cnt = 0;
  int         acc_mon = 0;

  // APB slave: decides pready/prdata half a cycle ahead of the sampling edge.
  always @(negedge clk) begin
    if (ifc.psel && ifc.penable) begin
      if (cur_waits != 255 && acc_cnt >= cur_waits) begin
        ifc.pready  = 1'b1;
        ifc.prdata  = mem[ifc.paddr];
        ifc.pslverr = cur_err;
        if (ifc.pwrite && !cur_err) mem[ifc.paddr] = ifc.pwdata;
      end else begin
        ifc.pready  = 1'b0;
        ifc.pslverr = 1'b0;
      end
      acc_cnt++;
    end else begin
      ifc.pready  = 1'b0;
      ifc.pslverr = 1'b0;
      ifc.prdata  = 8'h00;
      acc_cnt     = 0;
    end
  end

  always @(posedge clk) if (ifc.psel && ifc.penable) acc_mon++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [3:0] a, input logic [7:0] d,
                              input int waits, input logic er, input logic [7:0] xr,
                              input logic xe, input logic xt, input int xa);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.waits = waits; v.err = er;
    v.exp_rdata = xr; v.exp_err = xe; v.exp_to = xt; v.exp_acc = xa;
    return v;
  endfunction

  // Drive a command until accepted, then push its expected response.
  task automatic issue(input vec_t v);
    exp_t e;
    int   n;
    cur_waits     = v.waits;
    cur_err       = v.err;
    ifc.cmd_write = v.write;
    ifc.cmd_addr  = v.addr;
    ifc.cmd_wdata = v.wdata;
    ifc.cmd_valid = 1'b1;
    n = 0;
    while (!ifc.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.cmd_ready) chk("cmd_accept_timeout", 32'd0, 32'd1);
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.to = v.exp_to;
    sb.push_back(e);
    @(posedge clk);
    #1;
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic pop_cmp(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({name, "_rdata"},   32'(ifc.rsp_rdata),   32'(e.rdata));
    chk({name, "_err"},     32'(ifc.rsp_err),     32'(e.err));
    chk({name, "_timeout"}, 32'(ifc.rsp_timeout), 32'(e.to));
    chk({name, "_psel"},    32'(ifc.psel),        32'd0);
  endtask

  task automatic check_rsp(input string name);
    int n = 0;
    while (!ifc.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.rsp_valid) begin
      chk({name, "_rsp_wait_timeout"}, 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      pop_cmp(name);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [16];
    vec_t v;
    int   n;

    foreach (mem[i]) mem[i] = 8'h00;
    tbl[0]  = mk(1, 4'd0,  8'hDE, 0,   0, 8'h00, 0, 0, 1);
    tbl[1]  = mk(1, 4'd1,  8'hAD, 0,   0, 8'h00, 0, 0, 1);
    tbl[2]  = mk(1, 4'd2,  8'hBE, 0,   0, 8'h00, 0, 0, 1);
    tbl[3]  = mk(1, 4'd3,  8'hEF, 0,   0, 8'h00, 0, 0, 1);
    tbl[4]  = mk(0, 4'd0,  8'h00, 0,   0, 8'hDE, 0, 0, 1);
    tbl[5]  = mk(0, 4'd1,  8'h00, 0,   0, 8'hAD, 0, 0, 1);
    tbl[6]  = mk(0, 4'd2,  8'h00, 0,   0, 8'hBE, 0, 0, 1);
    tbl[7]  = mk(0, 4'd3,  8'h00, 0,   0, 8'hEF, 0, 0, 1);
    tbl[8]  = mk(1, 4'd5,  8'h5A, 0,   0, 8'h00, 0, 0, 1);
    tbl[9]  = mk(0, 4'd5,  8'h00, 3,   0, 8'h5A, 0, 0, 4);
    tbl[10] = mk(0, 4'd0,  8'h00, 255, 0, 8'h00, 1, 1, 16);
    tbl[11] = mk(0, 4'd3,  8'h00, 15,  0, 8'hEF, 0, 0, 16);
    tbl[12] = mk(0, 4'd1,  8'h00, 0,   1, 8'hAD, 1, 0, 1);
    tbl[13] = mk(1, 4'd4,  8'h11, 2,   1, 8'h00, 1, 0, 3);
    tbl[14] = mk(0, 4'd4,  8'h00, 1,   0, 8'h00, 0, 0, 2);
    tbl[15] = mk(1, 4'd15, 8'hFF, 255, 0, 8'h00, 1, 1, 16);

    rst_n = 1'b0;
    ifc.cmd_valid = 1'b0; ifc.cmd_write = 1'b0; ifc.cmd_addr = '0; ifc.cmd_wdata = '0;
    ifc.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_psel",      32'(ifc.psel),      32'd0);
    chk("rst_penable",   32'(ifc.penable),   32'd0);
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rsp_err",   32'(ifc.rsp_err),     32'd0);
    chk("rst_rsp_to",    32'(ifc.rsp_timeout), 32'd0);
    chk("rst_paddr",     32'(ifc.paddr),       32'd0);
    chk("rst_pwdata",    32'(ifc.pwdata),      32'd0);

    // Minimum-latency write, checked cycle by cycle.
    ifc.rsp_ready = 1'b1;
    issue(mk(1, 4'd0, 8'hDE, 0, 0, 8'h00, 0, 0, 1));
    chk("lat_T1_psel",    32'(ifc.psel),      32'd1);
    chk("lat_T1_penable", 32'(ifc.penable),   32'd0);
    chk("lat_T1_ready",   32'(ifc.cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("lat_T2_psel",    32'(ifc.psel),      32'd1);
    chk("lat_T2_penable", 32'(ifc.penable),   32'd1);
    chk("lat_T2_pwdata",  32'(ifc.pwdata),    32'hDE);
    chk("lat_T2_pwrite",  32'(ifc.pwrite),    32'd1);
    @(posedge clk); #1;
    chk("lat_T3_rsp_valid", 32'(ifc.rsp_valid), 32'd1);
    pop_cmp("lat_T3");
    @(posedge clk); #1;
    chk("lat_T4_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    chk("lat_T4_rsp_valid", 32'(ifc.rsp_valid), 32'd0);

    foreach (tbl[i]) begin
      acc_mon = 0;
      issue(tbl[i]);
      check_rsp($sformatf("vec%0d", i));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_access_cycles", i), 32'(acc_mon), 32'(tbl[i].exp_acc));
    end

    // Slave error held under backpressure, with a competing command pending.
    ifc.rsp_ready = 1'b0;
    issue(mk(0, 4'd2, 8'h00, 0, 1, 8'hBE, 1, 0, 1));
    check_rsp("bp");
    ifc.cmd_valid = 1'b1; ifc.cmd_write = 1'b1; ifc.cmd_addr = 4'd9; ifc.cmd_wdata = 8'h77;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", k), 32'(ifc.rsp_valid),   32'd1);
      chk($sformatf("bp%0d_rdata", k), 32'(ifc.rsp_rdata),   32'hBE);
      chk($sformatf("bp%0d_err", k),   32'(ifc.rsp_err),     32'd1);
      chk($sformatf("bp%0d_to", k),    32'(ifc.rsp_timeout), 32'd0);
      chk($sformatf("bp%0d_ready", k), 32'(ifc.cmd_ready),   32'd0);
    end
    ifc.cmd_valid = 1'b0;
    ifc.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("bp_released_ready", 32'(ifc.cmd_ready), 32'd1);
    @(negedge clk);
    chk("bp_stray_not_taken", 32'(ifc.psel), 32'd0);

    // Asynchronous reset while in ACCESS.
    issue(mk(0, 4'd1, 8'h00, 255, 0, 8'h00, 1, 1, 16));
    n = 0;
    while (!ifc.penable && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arst_reached_access", 32'(ifc.penable), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_psel",      32'(ifc.psel),      32'd0);
    chk("arst_penable",   32'(ifc.penable),   32'd0);
    chk("arst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    issue(mk(0, 4'd0, 8'h00, 0, 0, 8'hDE, 0, 0, 1));
    check_rsp("post_rst");
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(ifc.cmd_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
